// File: rtl/dyn7seg_to_static.sv
// dyn7seg_to_static
//
// Turns a multiplexed seven-segment bus (one shared segment pattern plus a
// one-hot digit strobe) into continuously driven, per-digit static outputs.
// A digit's pattern is stored only after it has been seen unchanged for
// settle_cycles consecutive samples. This rejects ghosting while the strobe
// moves between digits. A digit that stops being refreshed for
// timeout_cycles clocks is blanked. A global PWM enable dims every digit.
//
// Ports:
//   clk         the only clock
//   rst         asynchronous, active-high reset
//   abcdefgh    shared segment pattern, MSB = segment a, 1 = lit
//   digit       digit strobe, expected one-hot
//   brightness  PWM duty level: 0 = off, all-ones = always on
//   hex         static outputs, digit k at [k*w_seg +: w_seg], registered
//   refreshed   bit k high while digit k holds a value that has not timed out
//
// There is no handshake: every input is sampled on every clock.

`timescale 1ns/1ps

module dyn7seg_to_static #(
    parameter int n_digits          = 6,
    parameter int w_seg             = 8,
    parameter int reverse_seg_order = 1,
    parameter int active_low_out    = 1,
    parameter int settle_cycles     = 4,
    parameter int timeout_cycles    = 1_000_000,
    parameter int w_pwm             = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [w_seg-1:0]             abcdefgh,
    input  logic [n_digits-1:0]          digit,
    input  logic [w_pwm-1:0]             brightness,
    output logic [n_digits*w_seg-1:0]    hex,
    output logic [n_digits-1:0]          refreshed
);

    localparam int                      W_TO      = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [W_TO-1:0]         TO_MAX    = W_TO'(timeout_cycles);
    localparam logic [7:0]              SETTLE    = 8'(settle_cycles);
    localparam logic [n_digits*w_seg-1:0] HEX_UNLIT = {(n_digits*w_seg){active_low_out != 0}};

    // Input sample registers
    logic [w_seg-1:0]                   s_seg_q, s_seg_d;
    logic [n_digits-1:0]                s_dig_q, s_dig_d;

    // Settle filter
    logic [7:0]                         run_q, run_d;
    logic                               sat_q, sat_d;
    logic                               dig_onehot;
    logic                               same_sample;
    logic                               latch_fire;
    logic [n_digits-1:0]                latch_vec;

    // Per-digit stores and timeouts
    logic [n_digits-1:0][w_seg-1:0]     store_q, store_d;
    logic [n_digits-1:0][W_TO-1:0]      to_cnt_q, to_cnt_d;
    logic [n_digits-1:0]                refreshed_q, refreshed_d;
    logic [n_digits-1:0]                expire;

    // PWM and output stage
    logic [w_pwm-1:0]                   pwm_cnt_q, pwm_cnt_d;
    logic [w_pwm-1:0]                   bri_q, bri_d;
    logic                               pwm_en;
    logic [n_digits*w_seg-1:0]          hex_q, hex_d;
    logic [w_seg-1:0]                   lit_v;
    logic [w_seg-1:0]                   ord_v;

    always_comb begin : settle_logic
        s_seg_d     = abcdefgh;
        s_dig_d     = digit;
        dig_onehot  = (digit != '0) && ((digit & (digit - n_digits'(1))) == '0);
        same_sample = (abcdefgh == s_seg_q) && (digit == s_dig_q);
        sat_d       = 1'b0;
        run_d       = 8'd0;
        if (dig_onehot) begin
            if (same_sample) begin
                if (run_q == 8'hFF) begin
                    run_d = run_q;
                    sat_d = 1'b1;
                end else begin
                    run_d = run_q + 8'd1;
                end
            end else begin
                run_d = 8'd1;
            end
        end
        // sat_q marks a run that was already pinned at 255 on the previous
        // cycle. Without it, settle_cycles = 255 would re-fire every clock.
        latch_fire = (run_q == SETTLE) && !sat_q;
        // A non-zero run implies the sample that started it was one-hot, so
        // s_dig_q directly selects the store to write.
        latch_vec  = latch_fire ? s_dig_q : '0;
    end

    always_comb begin : digit_logic
        store_d     = store_q;
        to_cnt_d    = to_cnt_q;
        refreshed_d = refreshed_q;
        expire      = '0;
        for (int k = 0; k < n_digits; k++) begin
            if (TO_MAX == '0) begin
                to_cnt_d[k] = '0;
            end else if (latch_vec[k]) begin
                to_cnt_d[k] = '0;
            end else if (to_cnt_q[k] != TO_MAX) begin
                to_cnt_d[k] = to_cnt_q[k] + W_TO'(1);
            end
            // A digit blanks on the same edge its counter reaches the limit.
            // A latch on that edge takes priority.
            expire[k] = (TO_MAX != '0) && !latch_vec[k] && (to_cnt_d[k] == TO_MAX);
            if (latch_vec[k]) begin
                store_d[k]     = s_seg_q;
                refreshed_d[k] = 1'b1;
            end else if (expire[k]) begin
                store_d[k]     = '0;
                refreshed_d[k] = 1'b0;
            end
        end
    end

    always_comb begin : output_logic
        pwm_cnt_d = pwm_cnt_q + w_pwm'(1);
        // The duty is only reloaded at the period boundary, so a period is
        // never split between two brightness levels.
        bri_d     = (pwm_cnt_q == '1) ? brightness : bri_q;
        pwm_en    = (bri_q == '1) || (pwm_cnt_q < bri_q);
        lit_v     = '0;
        ord_v     = '0;
        hex_d     = '0;
        for (int k = 0; k < n_digits; k++) begin
            lit_v = store_q[k] & {w_seg{pwm_en}};
            for (int i = 0; i < w_seg; i++) begin
                ord_v[i] = (reverse_seg_order != 0) ? lit_v[w_seg-1-i] : lit_v[i];
            end
            hex_d[k*w_seg +: w_seg] = (active_low_out != 0) ? ~ord_v : ord_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg_q     <= '0;
            s_dig_q     <= '0;
            run_q       <= '0;
            sat_q       <= 1'b0;
            store_q     <= '0;
            to_cnt_q    <= '0;
            refreshed_q <= '0;
            pwm_cnt_q   <= '0;
            bri_q       <= '0;
            hex_q       <= HEX_UNLIT;
        end else begin
            s_seg_q     <= s_seg_d;
            s_dig_q     <= s_dig_d;
            run_q       <= run_d;
            sat_q       <= sat_d;
            store_q     <= store_d;
            to_cnt_q    <= to_cnt_d;
            refreshed_q <= refreshed_d;
            pwm_cnt_q   <= pwm_cnt_d;
            bri_q       <= bri_d;
            hex_q       <= hex_d;
        end
    end

    assign hex       = hex_q;
    assign refreshed = refreshed_q;

endmodule

// File: tb/tb_dyn7seg_to_static.sv
`timescale 1ns/1ps

module tb_dyn7seg_to_static;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int S  = 4;
    localparam int T  = 100;
    localparam int WP = 4;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    abcdefgh;
    logic [N-1:0]    digit;
    logic [WP-1:0]   brightness;
    logic [N*W-1:0]  hex;
    logic [N-1:0]    refreshed;

    always #5 clk = ~clk;

    dyn7seg_to_static #(
        .n_digits(N), .w_seg(W), .reverse_seg_order(1), .active_low_out(1),
        .settle_cycles(S), .timeout_cycles(T), .w_pwm(WP)
    ) dut (
        .clk(clk), .rst(rst), .abcdefgh(abcdefgh), .digit(digit),
        .brightness(brightness), .hex(hex), .refreshed(refreshed)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [N-1:0] dig;
        logic [W-1:0] seg;
        logic [W-1:0] exp_byte;
    } vec_t;

    vec_t            vecs[6];
    logic [N*W-1:0]  exp_q[$];
    logic [W-1:0]    exp_bytes[N];
    logic [N-1:0]    exp_ref;
    int              n_vec = 0;
    int              n_err = 0;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the strobe through the latch edge, then removes it.
    task automatic latch_digit(input logic [N-1:0] d, input logic [W-1:0] s);
        digit    = d;
        abcdefgh = s;
        repeat (S + 1) step();
        digit    = '0;
    endtask

    function automatic int idx_of(input logic [N-1:0] d);
        int r = 0;
        for (int i = 0; i < N; i++) if (d[i]) r = i;
        return r;
    endfunction

    function automatic logic [N*W-1:0] pack_exp();
        logic [N*W-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = exp_bytes[i];
        return r;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int lit_cnt;
        bit found;
        bit prev_lit;
        logic [W-1:0] old_b;

        vecs[0] = '{6'b000100, 8'hFC, 8'hC0};
        vecs[1] = '{6'b000001, 8'h60, 8'hF9};
        vecs[2] = '{6'b100000, 8'hDA, 8'hA4};
        vecs[3] = '{6'b010000, 8'hF2, 8'hB0};
        vecs[4] = '{6'b000010, 8'h01, 8'h7F};
        vecs[5] = '{6'b001000, 8'h80, 8'hFE};
        for (int i = 0; i < N; i++) exp_bytes[i] = 8'hFF;
        exp_ref = '0;

        rst        = 1'b1;
        digit      = '0;
        abcdefgh   = '0;
        brightness = 4'hF;
        #12;
        check("reset_hex", hex, 48'hFFFF_FFFF_FFFF);
        check("reset_refreshed", {42'd0, refreshed}, 48'd0);
        step();
        step();
        rst = 1'b0;
        check("post_reset_hex", hex, 48'hFFFF_FFFF_FFFF);
        check("post_reset_refreshed", {42'd0, refreshed}, 48'd0);
        // let bri_q pick up full brightness at a wrap
        repeat (20) step();
        check("idle_hex", hex, 48'hFFFF_FFFF_FFFF);

        // ---- table: one latch per digit ----
        for (int i = 0; i < 6; i++) begin
            k        = idx_of(vecs[i].dig);
            digit    = vecs[i].dig;
            abcdefgh = vecs[i].seg;
            old_b    = exp_bytes[k];
            exp_bytes[k] = vecs[i].exp_byte;
            exp_ref  = exp_ref | vecs[i].dig;
            exp_q.push_back(pack_exp());
            repeat (S + 1) step();
            check("tbl_refreshed", {42'd0, refreshed}, {42'd0, exp_ref});
            check("tbl_pre_hex", {40'd0, hex[k*W +: W]}, {40'd0, old_b});
            step();
            check("tbl_hex", hex, exp_q.pop_front());
        end

        // ---- glitch: 3 samples on digit 0, then digit 1 ----
        digit    = 6'b000001;
        abcdefgh = 8'hFF;
        repeat (3) step();
        digit    = 6'b000010;
        abcdefgh = 8'hB6;
        exp_bytes[1] = 8'h92;
        exp_q.push_back(pack_exp());
        repeat (S + 1) step();
        check("glitch_d0_kept", {40'd0, hex[7:0]}, {40'd0, 8'hF9});
        step();
        check("glitch_hex", hex, exp_q.pop_front());

        // ---- multi-hot then zero strobe: nothing latches ----
        digit    = 6'b000011;
        abcdefgh = 8'h00;
        repeat (20) step();
        check("multihot_hex", hex, pack_exp());
        check("multihot_refreshed", {42'd0, refreshed}, {42'd0, exp_ref});
        digit = '0;
        repeat (5) step();
        check("zero_strobe_hex", hex, pack_exp());

        // ---- timeout on digit 2 ----
        latch_digit(6'b000100, 8'h60);
        check("to_set", {47'd0, refreshed[2]}, 48'd1);
        repeat (T - 1) step();
        check("to_still_set", {47'd0, refreshed[2]}, 48'd1);
        check("to_still_lit", {40'd0, hex[23:16]}, {40'd0, 8'hF9});
        step();
        check("to_drop", {47'd0, refreshed[2]}, 48'd0);
        step();
        check("to_blank", {40'd0, hex[23:16]}, {40'd0, 8'hFF});

        // ---- re-latch on the exact timeout edge ----
        latch_digit(6'b000100, 8'h80);
        repeat (T - S - 1) step();
        digit    = 6'b000100;
        abcdefgh = 8'hDA;
        repeat (S + 1) step();
        check("relatch_refreshed", {47'd0, refreshed[2]}, 48'd1);
        check("relatch_old_hex", {40'd0, hex[23:16]}, {40'd0, 8'hFE});
        step();
        check("relatch_hex", {40'd0, hex[23:16]}, {40'd0, 8'hA4});
        digit = '0;

        // ---- PWM: brightness 4 ----
        brightness = 4'd4;
        repeat (17) step();
        lit_cnt = 0;
        repeat (16) begin
            if (hex[23:16] == 8'hA4) lit_cnt++;
            step();
        end
        check("pwm4_duty", 48'(lit_cnt), 48'd4);

        // ---- PWM: change mid-period, effective only after the wrap ----
        found    = 1'b0;
        prev_lit = (hex[23:16] == 8'hA4);
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if ((hex[23:16] == 8'hA4) && !prev_lit) found = 1'b1;
            prev_lit = (hex[23:16] == 8'hA4);
        end
        check("pwm_phase_found", {47'd0, found}, 48'd1);
        brightness = 4'hF;
        lit_cnt = 0;
        repeat (15) begin
            step();
            if (hex[23:16] == 8'hA4) lit_cnt++;
        end
        check("pwm_old_duty_kept", 48'(lit_cnt), 48'd3);
        lit_cnt = 0;
        repeat (16) begin
            step();
            if (hex[23:16] == 8'hA4) lit_cnt++;
        end
        check("pwm_new_duty", 48'(lit_cnt), 48'd16);

        // ---- PWM: brightness 0 ----
        latch_digit(6'b000100, 8'hF2);
        brightness = 4'd0;
        repeat (17) step();
        lit_cnt = 0;
        repeat (16) begin
            if (hex[23:16] != 8'hFF) lit_cnt++;
            step();
        end
        check("pwm0_duty", 48'(lit_cnt), 48'd0);

        // ---- asynchronous reset mid-run ----
        brightness = 4'hF;
        latch_digit(6'b000100, 8'hFC);
        repeat (17) step();
        check("pre_rst_lit", {40'd0, hex[23:16]}, {40'd0, 8'hC0});
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_hex", hex, 48'hFFFF_FFFF_FFFF);
        check("async_rst_refreshed", {42'd0, refreshed}, 48'd0);
        step();
        rst = 1'b0;
        repeat (20) step();
        check("post_rst_blank", hex, 48'hFFFF_FFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dyn7seg_to_static.md
# dyn7seg_to_static

Converts the multiplexed seven-segment bus produced by lab logic (one shared segment pattern plus a one-hot digit strobe) into independent, continuously driven static per-digit outputs for boards with static displays. It generalises the fixed six-digit sticky-flop scheme in the board tops:
- parametrised digit count, segment width, bit order and output polarity;
- a settle filter that rejects ghosting during digit transitions;
- a per-digit staleness timeout that blanks digits the lab logic stops refreshing;
- global PWM brightness.

The block sits between `common_top` and the board's `HEX*` pins in each board-specific top.

## Interface
Parameters:
- `n_digits`, 6: number of digits.
- `w_seg`, 8: segment bits per digit; input is ordered `abcdefgh`, with MSB = a.
- `reverse_seg_order`, 1: 1 drives output bit i from input bit `w_seg-1-i` (hgfedcba); 0 passes bits straight through.
- `active_low_out`, 1: 1 inverts the output, so a lit segment = 0.
- `settle_cycles`, 4: consecutive identical samples needed before a latch. Legal range 1..255.
- `timeout_cycles`, 1_000_000: clock cycles without a latch after which a digit blanks. 0 disables the timeout.
- `w_pwm`, 4: width of the brightness field and of the PWM counter.

Ports:
- `clk` input 1: the only clock.
- `rst` input 1: reset, asynchronous and active-high.
- `abcdefgh` input `w_seg`: segment pattern, 1 = lit.
- `digit` input `n_digits`: digit strobe, expected one-hot.
- `brightness` input `w_pwm`: duty level. 0 = off, all-ones = always on.
- `hex` output `n_digits*w_seg`: static outputs. Digit k occupies bits `[k*w_seg +: w_seg]`.
- `refreshed` output `n_digits`: bit k = 1 while digit k holds a non-timed-out value.

## Operation
- Input stage: `abcdefgh` and `digit` are registered into sample registers `s_seg` and `s_dig` every cycle.
- Settle counter `run` (8-bit, saturating):
  - If the new sample equals the previous sample and `digit` is exactly one-hot, `run` increments.
  - If `digit` is one-hot but the sample changed, `run` restarts at 1.
  - If `digit` is zero or multi-hot, `run` clears to 0.
- Latch: when `run == settle_cycles`, store k (k = index of `s_dig`) is written with `s_seg`. A latch fires once per stable run; while `run` is saturated no further writes occur, and the store already holds the value.
- Timeout counters, one per digit, saturating at `timeout_cycles`:
  - A latch to digit k clears counter k.
  - Otherwise counter k increments.
  - When counter k reaches `timeout_cycles`, store k clears to all-unlit and `refreshed[k]` drops.
  - A latch to digit k clears its timeout and sets `refreshed[k]`.
- PWM:
  - A free-running `w_pwm` counter wraps from all-ones to 0.
  - `brightness` is captured into `bri_q` only on the wrap edge, so the duty never changes mid-period.
  - Segments are enabled when `bri_q` is all-ones or `pwm_cnt < bri_q`.
- Output: `hex` is registered. Per digit: `store`, AND the PWM enable, then reorder if `reverse_seg_order`, then invert if `active_low_out`.
- Reset values:
  - all stores 0;
  - `refreshed` 0;
  - `run`, `pwm_cnt`, `bri_q` and all timeout counters 0;
  - `hex` = all-unlit, i.e. all ones when `active_low_out`=1, else 0.

## Timing
- Latency: with the input held stable across edges E1..E_S (S = `settle_cycles`):
  - the store updates at edge E_(S+1);
  - `refreshed[k]` rises at E_(S+1);
  - `hex` reflects the new value at E_(S+2), provided PWM is enabled on that cycle.
- Glitch rejection: a strobe pattern lasting fewer than S samples never latches.
- Simultaneous latch and timeout on the same digit in the same cycle: the latch wins, so the store takes the new value and `refreshed` stays 1.
- Latch to digit k while digit j times out: the two are independent, and both take effect in that cycle.
- Multi-hot or zero `digit`: no store changes, and timeouts keep counting.
- `rst` asserted mid-run: all state clears immediately without waiting for a clock edge. After release, `hex` stays all-unlit until the first latch.
- `timeout_cycles`=0: counters are held at 0 and never blank; `refreshed` stays 1 once set.
- `brightness` change: takes effect from the first PWM period after the next wrap, and at most 2^`w_pwm` cycles later.

## Test plan
- Reset with default parameters → `hex` = 48'hFFFF_FFFF_FFFF and `refreshed` = 0 during and immediately after reset.
- Drive `digit`=6'b000100, `abcdefgh`=8'b1111_1100 ("0"), `brightness`=4'hF, held stable, S=4 → `hex[23:16]` = ~8'b0011_1111 = 8'hC0 exactly 6 edges after the first sampling edge; `refreshed` = 6'b000100; other digits unchanged.
- Hold `digit`=6'b000001 for 3 cycles, then switch to 6'b000010, with S=4 → digit 0 store unchanged; digit 1 latches after 4 stable samples.
- Drive `digit`=6'b000011 (multi-hot) for 20 cycles → no store changes and `run` stays 0.
- `timeout_cycles`=100: latch digit 2, then stop the strobe → `refreshed[2]` falls and `hex[23:16]` returns to 8'hFF 100 cycles after the latch. Re-latching digit 2 on that exact cycle keeps it lit.
- `brightness`=4'd4 → each digit lit on exactly 4 of every 16 cycles. `brightness`=0 → never lit. Changing `brightness` mid-period alters the duty only after the wrap.
